// File: rtl/gaussian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// gaussian_stream_ctrl
//
// Sequences one frame through the separable 5-tap Gaussian filter datapath.
// The controller gates the filter clock enable, drives the filter pixel input
// and its synchronous clear, hides the filter fill latency (two lines plus two
// pixels) and drains the pipeline with zero pixels at the end of the frame.
//
// Ports
//   Clk, Reset_n             clock (rising edge), asynchronous active-low reset
//   start                    1-cycle pulse, begins a frame when idle
//   abort                    synchronous, drops the current frame (no done)
//   busy                     high whenever not idle
//   done                     1-cycle pulse after the last output is accepted
//   in_valid/in_ready/in_data        pixel source handshake
//   filt_din/filt_clk_en/filt_reset  filter datapath control
//   filt_dout                filter result (combinational in filt_din)
//   out_valid/out_ready/out_data     filtered pixel handshake
//   out_sof/out_eol/out_eof  frame/line markers, qualified by out_valid
// -----------------------------------------------------------------------------
module gaussian_stream_ctrl #(
    parameter int WIDTH  = 400,
    parameter int HEIGHT = 300
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic [7:0] filt_din,
    output logic       filt_clk_en,
    output logic       filt_reset,
    input  logic [7:0] filt_dout,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof
);

    localparam int LAT  = 2 * WIDTH + 2;
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int COLW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0]   LAT_LAST  = CW'(LAT - 1);
    localparam logic [CW-1:0]   NPIX_LAST = CW'(NPIX - 1);
    localparam logic [COLW-1:0] COL_LAST  = COLW'(WIDTH - 1);

    // S_ABORT is the clear cycle entered on abort: it drives exactly what
    // S_CLEAR drives but returns to S_IDLE instead of starting the fill.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_RUN,
        S_FLUSH,
        S_ABORT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     in_cnt;
    logic [CW-1:0]     out_cnt;
    logic [COLW-1:0]   col;
    logic              in_fire;
    logic              out_fire;
    logic              clearing;

    // Handshake events. In RUN one source pixel and one filtered pixel move
    // together so the filter only ever advances when the output is taken.
    always_comb begin
        in_fire  = 1'b0;
        out_fire = 1'b0;
        case (state)
            S_FILL:  in_fire = in_valid;
            S_RUN: begin
                in_fire  = in_valid & out_ready;
                out_fire = in_valid & out_ready;
            end
            S_FLUSH: out_fire = out_ready;
            default: ;
        endcase
    end

    assign clearing = (state == S_CLEAR) || (state == S_ABORT);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_ABORT;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_CLEAR;
                S_CLEAR: state_nxt = S_FILL;
                S_FILL:  if (in_fire && (in_cnt == LAT_LAST)) state_nxt = S_RUN;
                S_RUN:   if (in_fire && (in_cnt == NPIX_LAST)) state_nxt = S_FLUSH;
                S_FLUSH: if (out_fire && (out_cnt == NPIX_LAST)) state_nxt = S_IDLE;
                S_ABORT: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame counters and the registered done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            col     <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_FLUSH) && out_fire && (out_cnt == NPIX_LAST) && !abort;
            if (clearing) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                col     <= '0;
            end else begin
                if (in_fire) begin
                    in_cnt <= in_cnt + 1'b1;
                end
                if (out_fire) begin
                    out_cnt <= out_cnt + 1'b1;
                    col     <= (col == COL_LAST) ? '0 : col + 1'b1;
                end
            end
        end
    end

    // Output decode.
    always_comb begin
        busy        = (state != S_IDLE);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        filt_din    = '0;
        filt_clk_en = 1'b0;
        filt_reset  = !Reset_n || clearing;
        case (state)
            S_FILL: begin
                in_ready    = 1'b1;
                filt_din    = in_data;
                filt_clk_en = in_fire;
            end
            S_RUN: begin
                in_ready    = out_ready;
                out_valid   = in_valid;
                filt_din    = in_data;
                filt_clk_en = in_fire;
            end
            S_FLUSH: begin
                out_valid   = 1'b1;
                filt_clk_en = out_ready;
            end
            default: ;
        endcase
        out_data = filt_dout;
        out_sof  = out_valid && (out_cnt == '0);
        out_eol  = out_valid && (col == COL_LAST);
        out_eof  = out_valid && (out_cnt == NPIX_LAST);
    end

endmodule

// File: tb/tb_gaussian_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gaussian_stream_ctrl
//
// Bench for gaussian_stream_ctrl with WIDTH=4, HEIGHT=3. A stand-in filter
// (delay line of LAT samples plus a combinational term in din) sits behind the
// filter ports so every output value identifies the input pixel it belongs to.
// Stimulus pushes expected outputs into a queue; a monitor pops on accept.
// -----------------------------------------------------------------------------
module tb_gaussian_stream_ctrl;

    localparam int W    = 4;
    localparam int H    = 3;
    localparam int LAT  = 2 * W + 2;
    localparam int NPIX = W * H;

    typedef struct {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy;
    logic       done;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [7:0] filt_din;
    logic       filt_clk_en;
    logic       filt_reset;
    logic [7:0] filt_dout;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;

    gaussian_stream_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .filt_din(filt_din), .filt_clk_en(filt_clk_en), .filt_reset(filt_reset),
        .filt_dout(filt_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 Clk = ~Clk;

    // Stand-in filter: output = sample LAT advances old + 3 * current din.
    logic [7:0] line [LAT];
    always @(posedge Clk) begin
        if (filt_reset) begin
            for (int i = 0; i < LAT; i++) line[i] <= '0;
        end else if (filt_clk_en) begin
            line[0] <= filt_din;
            for (int i = 1; i < LAT; i++) line[i] <= line[i-1];
        end
    end
    assign filt_dout = line[LAT-1] + 8'(filt_din * 3);

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic [7:0] pix [NPIX];
    int   gen = 0;
    int   seen_gen = 0;
    int   in_fired = 0;
    int   acc_cnt = 0;
    int   stall_mode = 0;
    int   ready_mode = 0;
    bit   src_stop = 1'b0;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Output ready generator.
    initial begin
        int ph = 0;
        forever begin
            @(posedge Clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[ph];
                    ph = (ph + 1) % 4;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor / scoreboard.
    bit         done_exp = 1'b0;
    bit         hold_prev = 1'b0;
    logic [7:0] hold_data = '0;
    always @(negedge Clk) begin
        if (gen != seen_gen) begin
            seen_gen = gen;
            in_fired = 0;
            acc_cnt  = 0;
        end
        if (!Reset_n) begin
            done_exp  = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (done || done_exp) check("done_pulse", 32'(done), 32'(done_exp));
            done_exp = 1'b0;
            if (busy && !abort)
                check("clk_en_rule", 32'(filt_clk_en),
                      32'(in_ready ? in_valid : (out_valid & out_ready)));
            if (out_valid && !abort) check("no_valid_in_fill", 32'(in_fired >= LAT), 32'd1);
            if (hold_prev && out_valid && !abort) check("hold_data", 32'(out_data), 32'(hold_data));
            hold_prev = out_valid && !out_ready && !abort;
            hold_data = out_data;
            if (in_valid && in_ready && !abort) in_fired++;
            if (out_valid && out_ready && !abort) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_sof",  32'(out_sof),  32'(e.sof));
                    check("out_eol",  32'(out_eol),  32'(e.eol));
                    check("out_eof",  32'(out_eof),  32'(e.eof));
                    if (e.eof) done_exp = 1'b1;
                end
                acc_cnt++;
            end
        end
    end

    task automatic drive_source();
        int idx = 0;
        int stall = 0;
        bit s4 = 1'b0;
        bit s11 = 1'b0;
        bit fire;
        while (idx < NPIX && !src_stop) begin
            if (stall_mode == 1 && stall == 0 && ((idx == 4 && !s4) || (idx == 11 && !s11))) begin
                stall = 5;
                if (idx == 4) s4 = 1'b1; else s11 = 1'b1;
            end
            if (stall > 0) begin
                in_valid = 1'b0;
                stall--;
                @(negedge Clk);
                check("stall_clk_en", 32'(filt_clk_en), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd0);
                fire = 1'b0;
            end else begin
                in_valid = (stall_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data  = pix[idx];
                @(negedge Clk);
                fire = in_valid && in_ready;
            end
            @(posedge Clk);
            #1;
            if (fire) idx++;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Loads pixels, pushes the expected frame and pulses start (checking CLEAR).
    task automatic start_frame(input bit rnd, input int smode, input int rmode);
        gen++;
        exp_q.delete();
        for (int k = 0; k < NPIX; k++) pix[k] = rnd ? 8'($urandom_range(0, 255)) : 8'(k + 1);
        for (int k = 0; k < NPIX; k++) begin
            exp_t e;
            int   nxt;
            nxt    = (k + LAT < NPIX) ? int'(pix[k + LAT]) : 0;
            e.data = 8'(int'(pix[k]) + 3 * nxt);
            e.sof  = (k == 0);
            e.eol  = (k % W) == W - 1;
            e.eof  = (k == NPIX - 1);
            exp_q.push_back(e);
        end
        stall_mode = smode;
        ready_mode = rmode;
        @(posedge Clk);
        #1 start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
        @(negedge Clk);
        check("clear_filt_reset", 32'(filt_reset), 32'd1);
        check("clear_in_ready", 32'(in_ready), 32'd0);
        check("clear_busy", 32'(busy), 32'd1);
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done();
        int c = 0;
        bit seen = 1'b0;
        while (c < 800 && !seen) begin
            @(negedge Clk);
            seen = done;
            c++;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("out_count", 32'(acc_cnt), 32'(NPIX));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input bit rnd, input int smode, input int rmode, input bit poke_start);
        start_frame(rnd, smode, rmode);
        fork
            drive_source();
        join_none
        if (poke_start) begin
            repeat (3) @(posedge Clk);
            #1 start = 1'b1;
            @(posedge Clk);
            #1 start = 1'b0;
        end
        wait_done();
        wait fork;
    endtask

    task automatic wait_outputs(input int n);
        int c = 0;
        while (c < 400 && acc_cnt < n) begin
            @(negedge Clk);
            c++;
        end
        check("reach_outputs", 32'(acc_cnt >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_filt_reset", 32'(filt_reset), 32'd1);
        check("rst_filt_din", 32'(filt_din), 32'd0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check("idle_filt_reset", 32'(filt_reset), 32'd0);

        // Nominal frame, then start pulsed while busy.
        run_frame(1'b0, 0, 0, 1'b0);
        run_frame(1'b1, 0, 0, 1'b1);
        // Backpressure 1,0,0,1.
        run_frame(1'b1, 0, 1, 1'b0);
        // Source stalls in FILL and RUN.
        run_frame(1'b1, 1, 0, 1'b0);
        run_frame(1'b1, 1, 1, 1'b0);

        // Abort after output 1.
        start_frame(1'b1, 0, 0);
        fork
            drive_source();
        join_none
        wait_outputs(2);
        @(posedge Clk);
        #1 abort = 1'b1;
        src_stop = 1'b1;
        @(posedge Clk);
        #1 abort = 1'b0;
        @(negedge Clk);
        check("abort_clear_reset", 32'(filt_reset), 32'd1);
        check("abort_clear_busy", 32'(busy), 32'd1);
        check("abort_clear_valid", 32'(out_valid), 32'd0);
        @(negedge Clk);
        check("abort_idle", 32'(busy), 32'd0);
        wait fork;
        src_stop = 1'b0;
        exp_q.delete();
        repeat (5) @(negedge Clk);
        run_frame(1'b1, 0, 0, 1'b0);

        // Reset asserted mid-RUN.
        start_frame(1'b1, 0, 0);
        fork
            drive_source();
        join_none
        wait_outputs(1);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_filt_reset", 32'(filt_reset), 32'd1);
        src_stop = 1'b1;
        wait fork;
        src_stop = 1'b0;
        exp_q.delete();
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);

        // Random mixes.
        for (int f = 0; f < 4; f++) run_frame(1'b1, 2, 2, 1'b0);

        repeat (3) @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
